// File: rtl/tristate_bus_arbiter_if.sv
// Bundle of the request, enable, bus and receive signals shared between
// the tri-state bus arbiter and the drivers/receiver around it.
interface tristate_bus_arbiter_if #(
   parameter int WIDTH = 1
);
   logic [3:0]       req;
   logic [3:0]       oe;
   logic [1:0]       sel;
   logic [WIDTH-1:0] bus;
   logic [WIDTH-1:0] rx_data;
   logic             rx_valid;
   logic [1:0]       rx_src;
   logic             busy;

   // Arbiter side: sees requests and the resolved bus, owns everything else.
   modport master (
      input  req,
      input  bus,
      output oe,
      output sel,
      output rx_data,
      output rx_valid,
      output rx_src,
      output busy
   );

   // Driver/receiver side.
   modport slave (
      output req,
      output bus,
      input  oe,
      input  sel,
      input  rx_data,
      input  rx_valid,
      input  rx_src,
      input  busy
   );
endinterface

// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter for a four-driver tri-state bus. Issues a one-hot
// output enable, limits each grant to MAX_HOLD cycles and captures the
// resolved bus word every owned cycle.
// Optional feature macro: TSBUS_TURNAROUND_EN -- when defined, every grant
// is followed by TURNAROUND idle cycles (TURN state); when undefined grants
// switch back-to-back at a single edge.
module tristate_bus_arbiter #(
   parameter int WIDTH      = 1,
   parameter int MAX_HOLD   = 4,
   parameter int TURNAROUND = 1
) (
   input logic                     clk,
   input logic                     rst,
   tristate_bus_arbiter_if.master  bif
);

   localparam int HOLD_W = $clog2(MAX_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
   localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);

   // Reject parameter values outside their legal range at elaboration.
   if (MAX_HOLD < 1) begin : g_bad_hold
      $error("MAX_HOLD must be at least 1");
   end
   if (TURNAROUND < 1) begin : g_bad_turn
      $error("TURNAROUND must be at least 1");
   end

`ifdef TSBUS_TURNAROUND_EN
   localparam int TURN_W = $clog2(TURNAROUND + 1);
   localparam logic [TURN_W-1:0] TURN_LIMIT = TURN_W'(TURNAROUND);
   localparam logic [TURN_W-1:0] TURN_ONE   = TURN_W'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TURN  = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1
   } state_t;
`endif

   // Round-robin scan starting just after the previous owner; the previous
   // owner itself is checked last. Returns {found, index}.
   function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] l);
      logic [2:0] res;
      logic [1:0] idx;
      logic [1:0] step;
      res = 3'b000;
      // Lowest priority first so the highest-priority hit is written last.
      for (int k = 4; k >= 1; k--) begin
         step = 2'(k);
         idx  = l + step;
         if (r[idx]) begin
            res = {1'b1, idx};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   function automatic logic [3:0] onehot(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

   state_t            state_r;
   logic [1:0]        last_r;
   logic [1:0]        sel_r;
   logic [HOLD_W-1:0] hold_r;
   logic [3:0]        oe_r;
   logic [WIDTH-1:0]  rx_data_r;
   logic              rx_valid_r;
   logic [1:0]        rx_src_r;
   logic              busy_r;
`ifdef TSBUS_TURNAROUND_EN
   logic [TURN_W-1:0] turn_r;
`endif

   logic [2:0] pick_s;
   logic       found_s;
   logic [1:0] winner_s;

   assign pick_s   = rr_pick(bif.req, last_r);
   assign found_s  = pick_s[2];
   assign winner_s = pick_s[1:0];

   // Arbitration FSM; oe and all status outputs are registered with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= IDLE;
         last_r     <= 2'd3;
         sel_r      <= 2'd0;
         hold_r     <= '0;
         oe_r       <= 4'b0000;
         rx_data_r  <= '0;
         rx_valid_r <= 1'b0;
         rx_src_r   <= 2'd0;
         busy_r     <= 1'b0;
`ifdef TSBUS_TURNAROUND_EN
         turn_r     <= '0;
`endif
      end else begin
         rx_valid_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (found_s) begin
                  state_r <= GRANT;
                  sel_r   <= winner_s;
                  last_r  <= winner_s;
                  hold_r  <= HOLD_ONE;
                  oe_r    <= onehot(winner_s);
                  busy_r  <= 1'b1;
               end else begin
                  oe_r    <= 4'b0000;
                  busy_r  <= 1'b0;
               end
            end

            GRANT: begin
               rx_data_r  <= bif.bus;
               rx_src_r   <= sel_r;
               rx_valid_r <= 1'b1;
               if (!bif.req[sel_r] || (hold_r == HOLD_LIMIT)) begin
`ifdef TSBUS_TURNAROUND_EN
                  state_r <= TURN;
                  turn_r  <= TURN_ONE;
                  oe_r    <= 4'b0000;
                  busy_r  <= 1'b1;
`else
                  // last_r equals sel_r here, so the owner wins again only
                  // when it is the sole requester.
                  if (found_s) begin
                     state_r <= GRANT;
                     sel_r   <= winner_s;
                     last_r  <= winner_s;
                     hold_r  <= HOLD_ONE;
                     oe_r    <= onehot(winner_s);
                     busy_r  <= 1'b1;
                  end else begin
                     state_r <= IDLE;
                     oe_r    <= 4'b0000;
                     busy_r  <= 1'b0;
                  end
`endif
               end else begin
                  hold_r <= hold_r + HOLD_ONE;
               end
            end

`ifdef TSBUS_TURNAROUND_EN
            TURN: begin
               if (turn_r == TURN_LIMIT) begin
                  if (found_s) begin
                     state_r <= GRANT;
                     sel_r   <= winner_s;
                     last_r  <= winner_s;
                     hold_r  <= HOLD_ONE;
                     oe_r    <= onehot(winner_s);
                     busy_r  <= 1'b1;
                  end else begin
                     state_r <= IDLE;
                     oe_r    <= 4'b0000;
                     busy_r  <= 1'b0;
                  end
               end else begin
                  turn_r <= turn_r + TURN_ONE;
               end
            end
`endif

            default: begin
               state_r <= IDLE;
               oe_r    <= 4'b0000;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bif.oe       = oe_r;
   assign bif.sel      = sel_r;
   assign bif.rx_data  = rx_data_r;
   assign bif.rx_valid = rx_valid_r;
   assign bif.rx_src   = rx_src_r;
   assign bif.busy     = busy_r;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed bench for tristate_bus_arbiter: a vector table for the main
// grant/capture behaviour plus hand-written sequences for all-request
// rotation and asynchronous reset. Expectations follow TSBUS_TURNAROUND_EN.
module tb_tristate_bus_arbiter;

`ifdef TSBUS_TURNAROUND_EN
   localparam bit TA = 1'b1;
`else
   localparam bit TA = 1'b0;
`endif

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   tristate_bus_arbiter_if #(.WIDTH(8)) bif_a ();
   tristate_bus_arbiter_if #(.WIDTH(8)) bif_b ();

   tristate_bus_arbiter #(.WIDTH(8), .MAX_HOLD(4), .TURNAROUND(1)) dut_a (
      .clk (clk),
      .rst (rst),
      .bif (bif_a)
   );

   tristate_bus_arbiter #(.WIDTH(8), .MAX_HOLD(1), .TURNAROUND(1)) dut_b (
      .clk (clk),
      .rst (rst),
      .bif (bif_b)
   );

   // Word each driver places on the bus when enabled.
   function automatic logic [7:0] drv(input int i);
      case (i)
         0:       return 8'h11;
         1:       return 8'h22;
         2:       return 8'h33;
         3:       return 8'h44;
         default: return 8'h00;
      endcase
   endfunction

   // Bus resolution: enabled drivers OR together, idle bus pulls to 0.
   function automatic logic [7:0] resolve(input logic [3:0] oe);
      logic [7:0] r;
      r = 8'h00;
      for (int i = 0; i < 4; i++) begin
         if (oe[i]) r = r | drv(i);
      end
      return r;
   endfunction

   always_comb bif_a.bus = resolve(bif_a.oe);
   always_comb bif_b.bus = resolve(bif_b.oe);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] req;
      logic [3:0] oe;
      logic       valid;
      logic [1:0] src;
      logic [7:0] data;
      logic       busy;
   } vec_t;

   vec_t tbl[$];
   logic [3:0] exp_b[$];

   task automatic add(input logic [3:0] req, input logic [3:0] oe, input logic valid,
                      input logic [1:0] src, input logic [7:0] data, input logic busy);
      vec_t v;
      v.req = req; v.oe = oe; v.valid = valid; v.src = src; v.data = data; v.busy = busy;
      tbl.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      bif_a.req = 4'b0000;
      bif_b.req = 4'b0000;

      // Idle after reset.
      for (int i = 0; i < 5; i++) add(4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0);
      // Requester 1 holds: four enabled cycles, four strobes, then regrant.
      add(4'b0010, 4'b0010, 1'b0, 2'd0, 8'h00, 1'b1);
      for (int i = 0; i < 3; i++) add(4'b0010, 4'b0010, 1'b1, 2'd1, 8'h22, 1'b1);
      add(4'b0010, TA ? 4'b0000 : 4'b0010, 1'b1, 2'd1, 8'h22, 1'b1);
      add(4'b0010, 4'b0010, TA ? 1'b0 : 1'b1, 2'd1, 8'h22, 1'b1);
      add(4'b0000, 4'b0000, 1'b1, 2'd1, 8'h22, TA);
      add(4'b0000, 4'b0000, 1'b0, 2'd1, 8'h22, 1'b0);
      // Requester 2 drops after its second grant cycle.
      add(4'b0100, 4'b0100, 1'b0, 2'd1, 8'h22, 1'b1);
      add(4'b0100, 4'b0100, 1'b1, 2'd2, 8'h33, 1'b1);
      add(4'b0000, 4'b0000, 1'b1, 2'd2, 8'h33, TA);
      add(4'b0000, 4'b0000, 1'b0, 2'd2, 8'h33, 1'b0);
      // Round robin after owner 2: 3 beats 0, then 0 follows 3.
      add(4'b1001, 4'b1000, 1'b0, 2'd2, 8'h33, 1'b1);
      add(4'b0001, TA ? 4'b0000 : 4'b0001, 1'b1, 2'd3, 8'h44, 1'b1);
      add(4'b0001, 4'b0001, TA ? 1'b0 : 1'b1, TA ? 2'd3 : 2'd0, TA ? 8'h44 : 8'h11, 1'b1);
      add(4'b0000, 4'b0000, 1'b1, 2'd0, 8'h11, TA);
      add(4'b0000, 4'b0000, 1'b0, 2'd0, 8'h11, 1'b0);

      if (TA) begin
         exp_b = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                   4'b0000, 4'b1000, 4'b0000, 4'b0001};
      end else begin
         exp_b = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      end

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Table-driven main sequence on dut_a.
      for (int i = 0; i < tbl.size(); i++) begin
         bif_a.req = tbl[i].req;
         @(posedge clk);
         #1;
         check($sformatf("row%0d oe", i),       32'(bif_a.oe),       32'(tbl[i].oe));
         check($sformatf("row%0d rx_valid", i), 32'(bif_a.rx_valid), 32'(tbl[i].valid));
         check($sformatf("row%0d rx_src", i),   32'(bif_a.rx_src),   32'(tbl[i].src));
         check($sformatf("row%0d rx_data", i),  32'(bif_a.rx_data),  32'(tbl[i].data));
         check($sformatf("row%0d busy", i),     32'(bif_a.busy),     32'(tbl[i].busy));
      end

      // All four requesting with MAX_HOLD=1 on dut_b.
      bif_b.req = 4'b1111;
      for (int i = 0; i < exp_b.size(); i++) begin
         @(posedge clk);
         #1;
         check($sformatf("rot%0d oe", i), 32'(bif_b.oe), 32'(exp_b[i]));
         check($sformatf("rot%0d onehot0", i), 32'($onehot0(bif_b.oe)), 32'd1);
      end
      bif_b.req = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("drain%0d onehot0", i), 32'($onehot0(bif_b.oe)), 32'd1);
      end
      check("drain busy", 32'(bif_b.busy), 32'd0);
      check("drain oe", 32'(bif_b.oe), 32'd0);

      // Reset between edges while requester 1 owns the bus.
      bif_a.req = 4'b0010;
      @(posedge clk);
      #1;
      check("pre-reset oe", 32'(bif_a.oe), 32'b0010);
      #3 rst = 1'b1;
      #1;
      check("async reset oe", 32'(bif_a.oe), 32'd0);
      check("async reset busy", 32'(bif_a.busy), 32'd0);
      check("async reset sel", 32'(bif_a.sel), 32'd0);
      bif_a.req = 4'b1001;
      @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
      check("post-reset oe", 32'(bif_a.oe), 32'b0001);
      check("post-reset sel", 32'(bif_a.sel), 32'd0);
      check("post-reset rx_valid", 32'(bif_a.rx_valid), 32'd0);
      check("post-reset rx_data", 32'(bif_a.rx_data), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tristate_bus_arbiter.md
# tristate_bus_arbiter

Controller for a shared tri-state bus driven by four muxed drivers. Grants one requester at a time by asserting a one-hot output-enable, guarantees at most one enable is ever high, and by default inserts idle turnaround cycles between owners. It also samples the resolved bus every owned cycle and presents the captured word, with its source index, to the receiving logic.

## Interface
- `WIDTH`, default 1: bus width in bits.
- `MAX_HOLD`, default 4: maximum consecutive cycles one grant may last; legal range ≥1.
- `TURNAROUND`, default 1: idle cycles between grants when the turnaround feature is compiled in; legal range ≥1.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  4  per-driver bus request; level-sensitive.
- `oe`  out  4  one-hot driver enable; driver i drives `bus` only while `oe[i]`=1.
- `sel`  out  2  binary index of the current or most recent owner.
- `bus`  in  WIDTH  resolved shared bus wire.
- `rx_data`  out  WIDTH  last captured bus word.
- `rx_valid`  out  1  one-cycle strobe: `rx_data` updated this cycle.
- `rx_src`  out  2  owner index that drove `rx_data`.
- `busy`  out  1  high when state is not IDLE.

## Operation
- FSM states:
  - IDLE: `oe`=0.
  - GRANT: `oe`=onehot(`sel`).
  - TURN: `oe`=0, counting turnaround cycles.
- Round-robin pointer `last` holds the index of the previous owner. Arbitration scans `last+1`, `last+2`, `last+3`, `last` (mod 4) and picks the first asserted `req`.
- IDLE: when any `req` is set, pick the winner. At the next edge: `sel`←winner, `last`←winner, hold count←1, go to GRANT.
- GRANT: each edge captures `rx_data`←`bus`, `rx_src`←`sel`, `rx_valid`←1. The grant ends at the edge where `req[sel]`=0 or hold count=`MAX_HOLD`. Otherwise hold count increments.
- Grant end with the feature compiled in: go to TURN for `TURNAROUND` cycles. At the final TURN edge, arbitrate: go to GRANT if any `req` is set, else IDLE.
- Grant end with the feature compiled out: arbitrate immediately at the same edge. Go to GRANT for the winner (which may be the same owner if it is the only requester), else IDLE.
- Outside GRANT, `rx_valid`=0 and `rx_data`/`rx_src` hold their values.
- Invariant: `oe` has at most one bit set at all times. `oe` is driven directly from registered state with no combinational path from `req`.
- A `req` dropping during TURN or IDLE only affects the next arbitration.

## Timing
- Reset values: `oe`=0, `sel`=0, `rx_data`=0, `rx_valid`=0, `rx_src`=0, `busy`=0, state=IDLE. `last`=3, so requester 0 has first priority.
- Reset asserted mid-grant clears `oe` asynchronously, in the same cycle, releasing the bus.
- Latency from `req` to `oe`: 1 cycle. A `req` sampled high at edge N in IDLE gives `oe` high after edge N.
- Capture: the bus value present during GRANT cycle k appears on `rx_data`, with `rx_valid`=1, in cycle k+1.
- Hold: a continuously requesting owner gets exactly `MAX_HOLD` consecutive `oe` cycles.
- Grant gap: exactly `TURNAROUND` cycles with `oe`=0 when the feature is compiled in. Zero cycles when compiled out, with `oe` switching directly from one-hot i to one-hot j at a single edge.
- Simultaneous requests: resolved only by the round-robin order above. No requester waits more than 3 grants.

## Configuration
- `TSBUS_TURNAROUND_EN`:
  - Defined: the TURN state exists; every grant end produces `TURNAROUND` idle cycles with `oe`=0, avoiding driver overlap on slow enables.
  - Undefined: the TURN state and its counter are removed, `TURNAROUND` is ignored, and grants switch back-to-back.

## Test plan
- Reset, then `req`=4'b0000 for 5 cycles: `oe`=0, `busy`=0, `rx_valid`=0 throughout.
- `req`=4'b0010 held, drivers drive `bus`=1, `MAX_HOLD`=4:
  - `oe`=4'b0010 for exactly 4 cycles.
  - `rx_valid` pulses 4 times, with `rx_src`=1 and `rx_data`=1.
  - Then 1 TURN cycle, then regrant of requester 1.
- `req`=4'b1111 held, `MAX_HOLD`=1, macro defined: grant order 0,1,2,3,0, each grant separated by 1 idle cycle, and `$onehot0(oe)` holds always.
- Same stimulus, macro undefined: `oe` sequence 0001, 0010, 0100, 1000 on consecutive cycles with no zero cycles between them.
- Requester 2 drops `req` after its 2nd grant cycle: the grant ends after 2 cycles, and `rx_src`=2 for exactly 2 strobes.
- Assert `rst` mid-grant, between clock edges: `oe`=0 immediately. After release, the first grant goes to requester 0 when `req`=4'b1001.
